// File: rtl/input_scheduler.sv
// Button input scheduler: samples the game buttons on sample_tick, turns presses and
// held-direction auto-repeat into single commands, and hands them out over valid/ready.
module input_scheduler #(
    parameter int REPEAT_TICKS  = 2,
    parameter int FIRE_COOLDOWN = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sample_tick,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_fire,
    input  logic       btn_start,
    output logic       cmd_valid,
    output logic [1:0] cmd,
    input  logic       cmd_ready,
    output logic       fire_busy
);
    // state | meaning
    // IDLE  | nothing presented; takes the highest-priority pending button
    // ISSUE | cmd presented with cmd_valid=1, held until cmd_ready
    typedef enum logic {IDLE, ISSUE} state_t;

    localparam logic [3:0] REPEAT_CNT   = 4'(REPEAT_TICKS);
    localparam logic [3:0] COOLDOWN_CNT = 4'(FIRE_COOLDOWN);
    localparam int         B_LEFT  = 0;
    localparam int         B_RIGHT = 1;
    localparam int         B_FIRE  = 2;
    localparam int         B_START = 3;
    localparam logic [1:0] CMD_LEFT  = 2'b00;
    localparam logic [1:0] CMD_RIGHT = 2'b01;
    localparam logic [1:0] CMD_FIRE  = 2'b10;
    localparam logic [1:0] CMD_START = 2'b11;

    state_t     state, state_next;
    logic [1:0] cmd_q, cmd_next;
    logic [3:0] btn;
    logic [3:0] s1;
    logic [3:0] pending, pend_set, pend_clr;
    logic [3:0] hold_left, hold_right;
    logic [4:0] left_step, right_step;
    logic [3:0] cooldown;
    logic       cd_load;

    // Only the first sample stage feeds any decision, so only it is stored.
    assign btn = {btn_start, btn_fire, btn_right, btn_left};

    // Returns {repeat_event, next_count} for one direction on a sample tick.
    function automatic logic [4:0] hold_step(input logic b, input logic s, input logic [3:0] cnt);
        logic [3:0] inc;
        inc = cnt + 4'd1;
        if (!b)
            return 5'b0_0000;
        else if (!s)
            return {1'b0, cnt};
        else if (inc == REPEAT_CNT)
            return 5'b1_0000;
        else
            return {1'b0, inc};
    endfunction

    assign left_step  = hold_step(btn_left,  s1[B_LEFT],  hold_left);
    assign right_step = hold_step(btn_right, s1[B_RIGHT], hold_right);

    always_comb begin
        pend_set = '0;
        if (sample_tick) begin
            pend_set = btn & ~s1;
            if (cooldown != 4'd0)
                pend_set[B_FIRE] = 1'b0;
            pend_set[B_LEFT]  = pend_set[B_LEFT]  | left_step[4];
            pend_set[B_RIGHT] = pend_set[B_RIGHT] | right_step[4];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1         <= '0;
            pending    <= '0;
            hold_left  <= '0;
            hold_right <= '0;
            cooldown   <= '0;
        end else begin
            // A set on the same edge as a clear wins, so a fresh event is never lost.
            pending <= (pending & ~pend_clr) | pend_set;
            if (sample_tick) begin
                s1         <= btn;
                hold_left  <= left_step[3:0];
                hold_right <= right_step[3:0];
            end
            if (cd_load)
                cooldown <= COOLDOWN_CNT;
            else if (sample_tick && cooldown != 4'd0)
                cooldown <= cooldown - 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cmd_q <= CMD_LEFT;
        end else begin
            state <= state_next;
            cmd_q <= cmd_next;
        end
    end

    always_comb begin
        state_next = state;
        cmd_next   = cmd_q;
        pend_clr   = '0;
        cd_load    = 1'b0;
        case (state)
            IDLE: begin
                if (pending != 4'd0) begin
                    state_next = ISSUE;
                    if (pending[B_START])
                        cmd_next = CMD_START;
                    else if (pending[B_FIRE])
                        cmd_next = CMD_FIRE;
                    else if (pending[B_LEFT])
                        cmd_next = CMD_LEFT;
                    else
                        cmd_next = CMD_RIGHT;
                    pend_clr[cmd_next] = 1'b1;
                end
            end
            ISSUE: begin
                if (cmd_ready) begin
                    state_next = IDLE;
                    cd_load    = (cmd_q == CMD_FIRE);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign cmd_valid = (state == ISSUE);
    assign cmd       = cmd_q;
    assign fire_busy = (cooldown != 4'd0);
endmodule

// File: tb/tb_input_scheduler.sv
// Bench for input_scheduler: directed scenarios with fixed expectations, then random
// stimulus compared every cycle against a behavioural model of the button rules.
module tb_input_scheduler;
    localparam int REPEAT_TICKS  = 2;
    localparam int FIRE_COOLDOWN = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sample_tick = 1'b0;
    logic       btn_left = 1'b0, btn_right = 1'b0, btn_fire = 1'b0, btn_start = 1'b0;
    logic       cmd_ready = 1'b0;
    logic       cmd_valid;
    logic [1:0] cmd;
    logic       fire_busy;

    int tests_run = 0;
    int tests_failed = 0;
    int valid_cycles = 0;

    // Behavioural model state
    bit [3:0]   m_s1;
    bit [3:0]   m_pend;
    int         m_hold [2];
    int         m_cd;
    bit         m_valid;
    logic [1:0] m_cmd;

    input_scheduler #(
        .REPEAT_TICKS (REPEAT_TICKS),
        .FIRE_COOLDOWN(FIRE_COOLDOWN)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .sample_tick(sample_tick),
        .btn_left   (btn_left),
        .btn_right  (btn_right),
        .btn_fire   (btn_fire),
        .btn_start  (btn_start),
        .cmd_valid  (cmd_valid),
        .cmd        (cmd),
        .cmd_ready  (cmd_ready),
        .fire_busy  (fire_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp)
        else begin
            tests_failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock edge of the model, using the inputs present at that edge.
    function automatic void model_edge();
        bit [3:0] b;
        bit [3:0] set;
        int       win;
        bit       load;
        b = {btn_start, btn_fire, btn_right, btn_left};
        if (rst) begin
            m_s1 = '0; m_pend = '0; m_hold[0] = 0; m_hold[1] = 0;
            m_cd = 0; m_valid = 0; m_cmd = 2'b00;
            return;
        end
        set = '0;
        if (sample_tick) begin
            for (int i = 0; i < 4; i++)
                if (b[i] && !m_s1[i]) set[i] = 1'b1;
            if (m_cd != 0) set[2] = 1'b0;
            for (int d = 0; d < 2; d++) begin
                if (!b[d]) m_hold[d] = 0;
                else if (m_s1[d]) begin
                    m_hold[d]++;
                    if (m_hold[d] == REPEAT_TICKS) begin
                        m_hold[d] = 0;
                        set[d] = 1'b1;
                    end
                end
            end
            m_s1 = b;
        end
        load = 1'b0;
        if (!m_valid) begin
            win = -1;
            if (m_pend[3]) win = 3;
            else if (m_pend[2]) win = 2;
            else if (m_pend[0]) win = 0;
            else if (m_pend[1]) win = 1;
            if (win >= 0) begin
                m_pend[win] = 1'b0;
                m_valid = 1'b1;
                m_cmd = 2'(win);
            end
        end else if (cmd_ready) begin
            m_valid = 1'b0;
            load = (m_cmd == 2'b10);
        end
        if (load) m_cd = FIRE_COOLDOWN;
        else if (sample_tick && m_cd > 0) m_cd--;
        m_pend |= set;
    endfunction

    task automatic step(input logic tk);
        sample_tick = tk;
        @(posedge clk);
        model_edge();
        #1;
        sample_tick = 1'b0;
        if (cmd_valid === 1'b1) valid_cycles++;
        check("model_valid", 32'(cmd_valid), 32'(m_valid));
        check("model_busy", 32'(fire_busy), 32'(m_cd != 0));
        if (m_valid) check("model_cmd", 32'(cmd), 32'(m_cmd));
    endtask

    task automatic tick_gap(input int n);
        step(1'b1);
        repeat (n) step(1'b0);
    endtask

    task automatic do_reset();
        btn_left = 0; btn_right = 0; btn_fire = 0; btn_start = 0;
        rst = 1'b1;
        step(1'b0);
        rst = 1'b0;
    endtask

    initial begin
        // Reset values
        rst = 1'b1;
        step(1'b0);
        step(1'b0);
        rst = 1'b0;
        check("rst_valid", 32'(cmd_valid), 32'd0);
        check("rst_cmd", 32'(cmd), 32'd0);
        check("rst_busy", 32'(fire_busy), 32'd0);

        // Fire press with ready tied high, then cooldown behaviour
        cmd_ready = 1'b1;
        btn_fire = 1'b1;
        step(1'b1);
        check("fire_e0_valid", 32'(cmd_valid), 32'd0);
        step(1'b0);
        check("fire_e1_valid", 32'(cmd_valid), 32'd1);
        check("fire_e1_cmd", 32'(cmd), 32'd2);
        step(1'b0);
        check("fire_xfer_valid", 32'(cmd_valid), 32'd0);
        check("fire_xfer_busy", 32'(fire_busy), 32'd1);
        btn_fire = 1'b0;
        step(1'b0); step(1'b0);
        tick_gap(2);
        btn_fire = 1'b1;
        tick_gap(3);
        check("fire_drop_valid", 32'(cmd_valid), 32'd0);
        tick_gap(2);
        check("cool_tick3_busy", 32'(fire_busy), 32'd1);
        tick_gap(2);
        check("cool_tick4_busy", 32'(fire_busy), 32'd0);
        btn_fire = 1'b0;
        tick_gap(2);
        btn_fire = 1'b1;
        step(1'b1);
        step(1'b0);
        check("fire2_valid", 32'(cmd_valid), 32'd1);
        check("fire2_cmd", 32'(cmd), 32'd2);
        step(1'b0);
        check("fire2_busy", 32'(fire_busy), 32'd1);

        // Left held across ticks 0..6: press plus repeats on ticks 2, 4, 6
        do_reset();
        cmd_ready = 1'b1;
        valid_cycles = 0;
        btn_left = 1'b1;
        for (int t = 0; t < 7; t++) tick_gap(3);
        btn_left = 1'b0;
        for (int t = 0; t < 3; t++) tick_gap(3);
        check("left_repeat_count", 32'(valid_cycles), 32'd4);

        // Start and left on the same tick, consumer stalls for 5 cycles
        do_reset();
        cmd_ready = 1'b0;
        btn_start = 1'b1; btn_left = 1'b1;
        step(1'b1);
        btn_start = 1'b0; btn_left = 1'b0;
        step(1'b0);
        for (int c = 0; c < 5; c++) begin
            if (c > 0) step(1'b0);
            check("stall_valid", 32'(cmd_valid), 32'd1);
            check("stall_cmd", 32'(cmd), 32'd3);
        end
        cmd_ready = 1'b1;
        step(1'b0);
        check("start_xfer_gap", 32'(cmd_valid), 32'd0);
        step(1'b0);
        check("left_after_valid", 32'(cmd_valid), 32'd1);
        check("left_after_cmd", 32'(cmd), 32'd0);
        step(1'b0);

        // Reset mid-handshake, buttons released afterwards
        do_reset();
        cmd_ready = 1'b0;
        btn_start = 1'b1; btn_right = 1'b1;
        step(1'b1);
        btn_start = 1'b0; btn_right = 1'b0;
        step(1'b0);
        check("midrst_pre_cmd", 32'(cmd), 32'd3);
        rst = 1'b1;
        step(1'b0);
        check("midrst_valid", 32'(cmd_valid), 32'd0);
        check("midrst_cmd", 32'(cmd), 32'd0);
        check("midrst_busy", 32'(fire_busy), 32'd0);
        rst = 1'b0;
        valid_cycles = 0;
        for (int t = 0; t < 3; t++) tick_gap(3);
        check("midrst_quiet", 32'(valid_cycles), 32'd0);

        // Right held through reset: press on first tick after reset
        btn_start = 1'b1; btn_right = 1'b1;
        step(1'b1);
        btn_start = 1'b0;
        step(1'b0);
        rst = 1'b1;
        step(1'b0); step(1'b0);
        rst = 1'b0;
        step(1'b0); step(1'b0);
        check("held_rst_idle", 32'(cmd_valid), 32'd0);
        step(1'b1);
        check("held_e0_valid", 32'(cmd_valid), 32'd0);
        step(1'b0);
        check("held_e1_valid", 32'(cmd_valid), 32'd1);
        check("held_e1_cmd", 32'(cmd), 32'd1);
        cmd_ready = 1'b1;
        step(1'b0);
        btn_right = 1'b0;

        // Fire glitch strictly between ticks
        do_reset();
        cmd_ready = 1'b1;
        valid_cycles = 0;
        tick_gap(3);
        btn_fire = 1'b1;
        step(1'b0); step(1'b0); step(1'b0);
        btn_fire = 1'b0;
        step(1'b0);
        tick_gap(3);
        tick_gap(3);
        check("glitch_cmds", 32'(valid_cycles), 32'd0);
        check("glitch_busy", 32'(fire_busy), 32'd0);

        // Random stimulus against the model
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 5) == 0) begin
                case ($urandom_range(0, 3))
                    0: btn_left  = ~btn_left;
                    1: btn_right = ~btn_right;
                    2: btn_fire  = ~btn_fire;
                    default: btn_start = ~btn_start;
                endcase
            end
            cmd_ready = ($urandom_range(0, 2) != 0);
            rst = ($urandom_range(0, 299) == 0);
            step($urandom_range(0, 3) == 0);
        end
        rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
